// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants and types for the 2-to-4 decoder
//
// Purpose : output width, idle (deselected) output value and the one-cold
//           output vector type used by decoder_2x4_gates.
// Ports   : none (package).
package decoder_pkg;

  localparam int unsigned DEC_OUT_W = 4;

  // Active-low outputs: all ones means nothing is selected.
  localparam logic [DEC_OUT_W-1:0] DEC_IDLE = 4'b1111;

  typedef logic [DEC_OUT_W-1:0] dec_out_t;

endpackage : decoder_pkg

// File: rtl/decoder_nand3.sv
// rtl/decoder_nand3.sv - 3-input NAND cell
//
// Purpose : single NAND3 gate; the decoder uses one per output line.
// Ports   : a, b, c - gate inputs
//           y       - ~(a & b & c)
module decoder_nand3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  // Plain gate semantics: any 0 input forces y = 1 even if another input is X.
  assign y = ~(a & b & c);

endmodule : decoder_nand3

// File: rtl/decoder_2x4_gates.sv
// rtl/decoder_2x4_gates.sv - gate-level 2-to-4 decoder with active-low outputs
//
// Purpose : decodes {A,B} into a one-cold active-low vector D when enable is
//           high; D = 4'b1111 when disabled. Optional registered output stage
//           is compiled in with DECODER_2X4_GATES_REG_OUT_EN.
// Ports   : clk    - clock (registered build only)
//           rst_n  - asynchronous active-low reset (registered build only)
//           enable - active-high decoder enable
//           A      - select MSB
//           B      - select LSB
//           D      - active-low decoded outputs, D[i] low selects i = {A,B}
// Macro   : DECODER_2X4_GATES_REG_OUT_EN - adds a 4-bit output register
//           (reset value 4'b1111) between the NAND3 cells and D.
module decoder_2x4_gates
  import decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 A,
  input  logic                 B,
  output logic [DEC_OUT_W-1:0] D
);

  // Select inverters, shared by all four NAND3 cells.
  logic a_n;
  logic b_n;

  assign a_n = ~A;
  assign b_n = ~B;

  dec_out_t nand_out;

  decoder_nand3 u_nand_0 (.a(a_n), .b(b_n), .c(enable), .y(nand_out[0]));
  decoder_nand3 u_nand_1 (.a(a_n), .b(B),   .c(enable), .y(nand_out[1]));
  decoder_nand3 u_nand_2 (.a(A),   .b(b_n), .c(enable), .y(nand_out[2]));
  decoder_nand3 u_nand_3 (.a(A),   .b(B),   .c(enable), .y(nand_out[3]));

`ifdef DECODER_2X4_GATES_REG_OUT_EN

  dec_out_t d_q;

  // Reset drops D to the deselected value immediately; release is seen at
  // the next rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= DEC_IDLE;
    end else begin
      d_q <= nand_out;
    end
  end

  assign D = d_q;

`else

  assign D = nand_out;

  // clk and rst_n have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

`endif

endmodule : decoder_2x4_gates

// File: tb/tb_decoder_2x4_gates.sv
// tb/tb_decoder_2x4_gates.sv - self-checking bench for decoder_2x4_gates
module tb_decoder_2x4_gates;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       A;
  logic       B;
  logic [3:0] D;

  int checks;
  int errors;

  logic [3:0] exp_q[$];

  decoder_2x4_gates dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .A      (A),
    .B      (B),
    .D      (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: one-cold active-low decode.
  function automatic logic [3:0] ref_decode(input logic en, input logic a, input logic b);
    logic [3:0] r;
    r = 4'b1111;
    if (en) r[{a, b}] = 1'b0;
    return r;
  endfunction

  // Drive inputs just after a rising edge and push the expected output.
  task automatic drive(input logic en, input logic a, input logic b);
    @(posedge clk);
    #1;
    enable = en;
    A      = a;
    B      = b;
    exp_q.push_back(ref_decode(en, a, b));
  endtask

  // Wait for the DUT latency, then pop and compare.
  task automatic check(input string tag);
    logic [3:0] exp;
`ifdef DECODER_2X4_GATES_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #3;
`endif
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed %b", tag, D);
    end else begin
      exp = exp_q.pop_front();
      assert (D === exp) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, D, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    A      = 1'b0;
    B      = 1'b0;

    // Reset / idle state.
    #2;
    checks++;
    assert (D === 4'b1111) else begin
      errors++;
      $error("FAIL reset_state: observed %b expected %b", D, 4'b1111);
    end

    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Disabled sweep.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i[1], i[0]);
      check($sformatf("dis_sweep_%0d", i));
    end

    // Enabled sweep.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[1], i[0]);
      check($sformatf("en_sweep_%0d", i));
    end

    // Disable dominates unknown selects.
    @(posedge clk);
    #1;
    enable = 1'b0;
    A      = 1'bx;
    B      = 1'bx;
    exp_q.push_back(4'b1111);
    check("dis_x_sel");

    // enable=1, A unknown, B=0: lines 1 and 3 stay deselected.
    @(posedge clk);
    #1;
    enable = 1'b1;
    A      = 1'bx;
    B      = 1'b0;
`ifdef DECODER_2X4_GATES_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #3;
`endif
    checks++;
    assert ({D[3], D[1]} === 2'b11) else begin
      errors++;
      $error("FAIL en_x_a_d31: observed %b expected %b", {D[3], D[1]}, 2'b11);
    end

    // Enable toggle with {A,B}=10.
    drive(1'b1, 1'b1, 1'b0);
    check("tog_on_1");
    drive(1'b0, 1'b1, 1'b0);
    check("tog_off");
    drive(1'b1, 1'b1, 1'b0);
    check("tog_on_2");

    // Random directed mix.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      drive(v[2], v[1], v[0]);
      check($sformatf("rand_%0d", i));
    end

`ifdef DECODER_2X4_GATES_REG_OUT_EN
    // Reset immediately forces idle, without a clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (D === 4'b1111) else begin
      errors++;
      $error("FAIL async_reset: observed %b expected %b", D, 4'b1111);
    end

    // Release with enable=1, {A,B}=11 applied in the same cycle.
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    A      = 1'b1;
    B      = 1'b1;
    checks++;
    assert (D === 4'b1111) else begin
      errors++;
      $error("FAIL held_before_edge: observed %b expected %b", D, 4'b1111);
    end
    exp_q.push_back(4'b0111);
    check("post_release");

    // Mid-stream reset while D = 1101.
    drive(1'b1, 1'b0, 1'b1);
    check("pre_mid_reset");
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (D === 4'b1111) else begin
      errors++;
      $error("FAIL mid_reset: observed %b expected %b", D, 4'b1111);
    end
    #1;
    rst_n = 1'b1;
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_decoder_2x4_gates
